// File: rtl/io_responder.sv
// io_responder: memory-mapped I/O block for a small CPU.
//
// It debounces the pushbuttons and switches, keeps sticky key-press flags,
// runs a millisecond timer with a programmable wrap limit, and holds the
// HEX/LEDR/LEDG output registers. Reads are combinational (zero latency).
// Writes commit on the rising CLK edge.
//
// Ports:
//   CLK     - the only clock, rising edge
//   RESET_N - asynchronous active-low reset
//   ADDR    - CPU data-side address
//   DIN     - CPU write data
//   WE      - CPU write strobe
//   DOUT    - read data, 0 when SEL is low
//   SEL     - high when ADDR hits one of the mapped registers
//   KEY     - raw pushbuttons, active-low
//   SW      - raw slide switches
//   HEXVAL  - value shown on the four seven-segment digits
//   LEDR    - red LEDs
//   LEDG    - green LEDs
//
// Register map:
//   FFF0 KDATA (ro)  FFF2 SDATA (ro)  FFF4 KSTAT (w1c)  FFF6 TCNT
//   FFF8 HEX         FFFA LEDR        FFFC LEDG         FFFE TLIM
module io_responder #(
    parameter int DBITS      = 16,
    parameter int DEB_CYCLES = 500000,
    parameter int PRESCALE   = 50000
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [DBITS-1:0] ADDR,
    input  logic [DBITS-1:0] DIN,
    input  logic             WE,
    output logic [DBITS-1:0] DOUT,
    output logic             SEL,
    input  logic [3:0]       KEY,
    input  logic [9:0]       SW,
    output logic [15:0]      HEXVAL,
    output logic [9:0]       LEDR,
    output logic [7:0]       LEDG
);

    localparam int NIN = 14;
    localparam int CW  = $clog2(DEB_CYCLES + 1);
    localparam int PW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [DBITS-1:0] A_KDATA = DBITS'(16'hFFF0);
    localparam logic [DBITS-1:0] A_SDATA = DBITS'(16'hFFF2);
    localparam logic [DBITS-1:0] A_KSTAT = DBITS'(16'hFFF4);
    localparam logic [DBITS-1:0] A_TCNT  = DBITS'(16'hFFF6);
    localparam logic [DBITS-1:0] A_HEX   = DBITS'(16'hFFF8);
    localparam logic [DBITS-1:0] A_LEDR  = DBITS'(16'hFFFA);
    localparam logic [DBITS-1:0] A_LEDG  = DBITS'(16'hFFFC);
    localparam logic [DBITS-1:0] A_TLIM  = DBITS'(16'hFFFE);

    logic [NIN-1:0]    w_raw;
    logic [NIN-1:0]    r_sync1;
    logic [NIN-1:0]    r_sync2;
    logic [NIN-1:0]    r_deb;
    logic [NIN-1:0]    w_debNext;
    logic [NIN*CW-1:0] r_debCnt;
    logic [NIN*CW-1:0] w_cntNext;

    logic [PW-1:0] r_pre;
    logic [15:0]   r_tcnt;
    logic [15:0]   r_tlim;
    logic [4:0]    r_kstat;
    logic [15:0]   r_hex;
    logic [9:0]    r_ledr;
    logic [7:0]    r_ledg;

    logic        w_wrKstat;
    logic        w_wrTcnt;
    logic        w_tick;
    logic        w_limHit;
    logic        w_wrapEvent;
    logic [3:0]  w_keyRise;
    logic [4:0]  w_clr;
    logic [15:0] w_rdata;
    logic        w_sel;

    // Keys are inverted before synchronizing so that every reset value of
    // zero (sync flops and debounced state) means "not pressed".
    assign w_raw = {SW, ~KEY};

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_deb    <= '0;
            r_debCnt <= '0;
        end else begin
            r_sync1  <= w_raw;
            r_sync2  <= r_sync1;
            r_deb    <= w_debNext;
            r_debCnt <= w_cntNext;
        end
    end

    // A counter only advances while the synced input disagrees with the
    // accepted value; any agreement, or the accepting edge itself, clears it.
    always_comb begin
        w_debNext = r_deb;
        w_cntNext = '0;
        for (int i = 0; i < NIN; i++) begin
            if (r_sync2[i] != r_deb[i]) begin
                if (r_debCnt[i*CW +: CW] == CW'(DEB_CYCLES - 1)) begin
                    w_debNext[i] = r_sync2[i];
                end else begin
                    w_cntNext[i*CW +: CW] = r_debCnt[i*CW +: CW] + CW'(1);
                end
            end
        end
    end

    assign w_keyRise = w_debNext[3:0] & ~r_deb[3:0];
    assign w_wrKstat = WE && (ADDR == A_KSTAT);
    assign w_wrTcnt  = WE && (ADDR == A_TCNT);
    assign w_tick    = (r_pre == PW'(PRESCALE - 1));
    assign w_limHit  = (r_tlim != 16'd0) && (r_tcnt == r_tlim);
    // A CPU load of TCNT suppresses the tick, so it cannot report a wrap.
    assign w_wrapEvent = w_tick && w_limHit && !w_wrTcnt;
    assign w_clr       = w_wrKstat ? DIN[4:0] : 5'd0;

    // Equality (not >=) against the limit lets a limit written below the
    // current count run through 0xFFFF and wrap silently.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_pre  <= '0;
            r_tcnt <= '0;
        end else if (w_wrTcnt) begin
            r_pre  <= '0;
            r_tcnt <= DIN[15:0];
        end else if (w_tick) begin
            r_pre  <= '0;
            r_tcnt <= w_limHit ? 16'd0 : r_tcnt + 16'd1;
        end else begin
            r_pre  <= r_pre + PW'(1);
        end
    end

    // Set events are OR-ed in after the clear mask so a same-edge set wins.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_kstat <= '0;
        end else begin
            r_kstat <= (r_kstat & ~w_clr) | {w_wrapEvent, w_keyRise};
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_hex  <= '0;
            r_ledr <= '0;
            r_ledg <= '0;
            r_tlim <= '0;
        end else if (WE) begin
            if (ADDR == A_HEX)  r_hex  <= DIN[15:0];
            if (ADDR == A_LEDR) r_ledr <= DIN[9:0];
            if (ADDR == A_LEDG) r_ledg <= DIN[7:0];
            if (ADDR == A_TLIM) r_tlim <= DIN[15:0];
        end
    end

    always_comb begin
        w_sel   = 1'b1;
        w_rdata = 16'd0;
        case (ADDR)
            A_KDATA: w_rdata = {12'd0, r_deb[3:0]};
            A_SDATA: w_rdata = {6'd0, r_deb[13:4]};
            A_KSTAT: w_rdata = {11'd0, r_kstat};
            A_TCNT:  w_rdata = r_tcnt;
            A_HEX:   w_rdata = r_hex;
            A_LEDR:  w_rdata = {6'd0, r_ledr};
            A_LEDG:  w_rdata = {8'd0, r_ledg};
            A_TLIM:  w_rdata = r_tlim;
            default: w_sel   = 1'b0;
        endcase
    end

    assign SEL    = w_sel;
    assign DOUT   = DBITS'(w_rdata);
    assign HEXVAL = r_hex;
    assign LEDR   = r_ledr;
    assign LEDG   = r_ledg;

endmodule

// File: tb/tb_io_responder.sv
// tb_io_responder: self-checking bench for io_responder with short debounce
// and prescale constants. A behavioural model tracks the register map from
// the rules of the block: an input is accepted once its synchronized value
// has disagreed with the accepted value for DEB consecutive samples, the
// timer ticks every PRE cycles after the last load or reset, and KSTAT is
// clear-then-set. Every cycle all mapped registers and the LED outputs are
// compared, with directed scenarios mixed in ahead of a random phase.
`timescale 1ns/100ps
module tb_io_responder;

    localparam int DEB = 4;
    localparam int PRE = 10;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [15:0] ADDR;
    logic [15:0] DIN;
    logic        WE;
    logic [15:0] DOUT;
    logic        SEL;
    logic [3:0]  KEY;
    logic [9:0]  SW;
    logic [15:0] HEXVAL;
    logic [9:0]  LEDR;
    logic [7:0]  LEDG;

    int vectors     = 0;
    int miscompares = 0;

    // Model state
    logic [13:0] mQ[$];
    logic [13:0] mDeb;
    logic [4:0]  mKstat;
    logic [15:0] mTcnt;
    logic [15:0] mTlim;
    logic [15:0] mHex;
    logic [9:0]  mLedr;
    logic [7:0]  mLedg;
    int          mSince;

    logic [3:0]  curKey;
    logic [9:0]  curSw;

    io_responder #(.DBITS(16), .DEB_CYCLES(DEB), .PRESCALE(PRE)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .ADDR(ADDR), .DIN(DIN), .WE(WE),
        .DOUT(DOUT), .SEL(SEL), .KEY(KEY), .SW(SW),
        .HEXVAL(HEXVAL), .LEDR(LEDR), .LEDG(LEDG)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] mapAddr(input int i);
        return 16'hFFF0 + 16'(2 * i);
    endfunction

    // Returns {sel, data} expected for a read of address a.
    function automatic logic [16:0] expectRead(input logic [15:0] a);
        case (a)
            16'hFFF0: return {1'b1, 12'd0, mDeb[3:0]};
            16'hFFF2: return {1'b1, 6'd0, mDeb[13:4]};
            16'hFFF4: return {1'b1, 11'd0, mKstat};
            16'hFFF6: return {1'b1, mTcnt};
            16'hFFF8: return {1'b1, mHex};
            16'hFFFA: return {1'b1, 6'd0, mLedr};
            16'hFFFC: return {1'b1, 8'd0, mLedg};
            16'hFFFE: return {1'b1, mTlim};
            default:  return 17'd0;
        endcase
    endfunction

    task automatic modelReset();
        mQ.delete();
        mQ.push_back(14'd0);
        mQ.push_back(14'd0);
        mDeb   = '0;
        mKstat = '0;
        mTcnt  = '0;
        mTlim  = '0;
        mHex   = '0;
        mLedr  = '0;
        mLedg  = '0;
        mSince = 0;
    endtask

    // One rising edge of the model. The queue holds the raw samples; the
    // oldest DEB of them are the values the synchronizer presents now.
    task automatic modelStep(input logic [3:0] key, input logic [9:0] sw,
                             input logic [15:0] addr, input logic [15:0] din, input logic we);
        logic [13:0] newDeb;
        logic [4:0]  clr;
        logic        tick;
        logic        wrapEv;
        mQ.push_back({sw, ~key});
        if (mQ.size() > DEB + 2) void'(mQ.pop_front());
        newDeb = mDeb;
        if (mQ.size() == DEB + 2) begin
            for (int i = 0; i < 14; i++) begin
                bit allDiff;
                allDiff = 1'b1;
                for (int j = 0; j < DEB; j++)
                    if (mQ[j][i] == mDeb[i]) allDiff = 1'b0;
                if (allDiff) newDeb[i] = ~mDeb[i];
            end
        end
        wrapEv = 1'b0;
        if (we && addr == 16'hFFF6) begin
            mTcnt  = din;
            mSince = 0;
        end else begin
            tick = ((mSince % PRE) == PRE - 1);
            mSince++;
            if (tick) begin
                if (mTlim != 0 && mTcnt == mTlim) begin
                    mTcnt  = 16'd0;
                    wrapEv = 1'b1;
                end else begin
                    mTcnt = mTcnt + 16'd1;
                end
            end
        end
        clr    = (we && addr == 16'hFFF4) ? din[4:0] : 5'd0;
        mKstat = (mKstat & ~clr) | {wrapEv, newDeb[3:0] & ~mDeb[3:0]};
        if (we && addr == 16'hFFF8) mHex  = din;
        if (we && addr == 16'hFFFA) mLedr = din[9:0];
        if (we && addr == 16'hFFFC) mLedg = din[7:0];
        if (we && addr == 16'hFFFE) mTlim = din;
        mDeb = newDeb;
    endtask

    task automatic compareAll(input string phase);
        checkOutput({phase, ".hexval"}, HEXVAL, mHex);
        checkOutput({phase, ".ledr"}, {6'd0, LEDR}, {6'd0, mLedr});
        checkOutput({phase, ".ledg"}, {8'd0, LEDG}, {8'd0, mLedg});
        for (int i = 0; i < 9; i++) begin
            logic [15:0] a;
            logic [16:0] e;
            a = (i < 8) ? mapAddr(i) : 16'h1000 + 16'($urandom_range(0, 4095));
            ADDR = a;
            WE   = 1'b0;
            #0.1;
            e = expectRead(a);
            checkOutput({phase, ".sel"}, {15'd0, SEL}, {15'd0, e[16]});
            checkOutput({phase, ".dout"}, DOUT, e[15:0]);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] key, input logic [9:0] sw, input logic [15:0] addr,
                                 input logic [15:0] din, input logic we, input string phase);
        KEY  = key;
        SW   = sw;
        ADDR = addr;
        DIN  = din;
        WE   = we;
        modelStep(key, sw, addr, din, we);
        @(posedge CLK);
        #1;
        compareAll(phase);
    endtask

    task automatic idle(input string phase);
        applyStimulus(curKey, curSw, 16'hFFF0, 16'd0, 1'b0, phase);
    endtask

    task automatic readCheck(input string tag, input logic [15:0] a, input logic [15:0] exp);
        ADDR = a;
        WE   = 1'b0;
        #0.1;
        checkOutput(tag, DOUT, exp);
    endtask

    task automatic doReset(input string phase);
        RESET_N = 1'b0;
        WE      = 1'b0;
        KEY     = curKey;
        SW      = curSw;
        modelReset();
        #1;
        checkOutput({phase, ".hex0"}, HEXVAL, 16'h0000);
        readCheck({phase, ".tcnt0"}, 16'hFFF6, 16'h0000);
        readCheck({phase, ".unmapped"}, 16'h1234, 16'h0000);
        checkOutput({phase, ".sel0"}, {15'd0, SEL}, 16'h0000);
        compareAll(phase);
        @(posedge CLK);
        #2;
        RESET_N = 1'b1;
    endtask

    initial begin
        curKey = 4'b1101;
        curSw  = 10'd0;
        ADDR   = 16'd0;
        DIN    = 16'd0;
        WE     = 1'b0;
        doReset("reset");

        // Key 1 held from reset release
        for (int c = 1; c <= 6; c++) begin
            idle("keypress");
            if (c == 5) readCheck("kdata.e5", 16'hFFF0, 16'h0000);
        end
        readCheck("kdata.e6", 16'hFFF0, 16'h0002);
        readCheck("kstat.e6", 16'hFFF4, 16'h0002);
        applyStimulus(curKey, curSw, 16'hFFF4, 16'h0002, 1'b1, "kstat.w1c");
        readCheck("kstat.cleared", 16'hFFF4, 16'h0000);

        // Switch bounce shorter than the debounce window
        curKey = 4'b1111;
        for (int c = 0; c < 30; c++) begin
            curSw = {9'd0, ((c / 3) % 2) == 0};
            idle("bounce");
            readCheck("sdata.bounce", 16'hFFF2, 16'h0000);
        end
        curSw = 10'd1;
        for (int c = 1; c <= 6; c++) begin
            idle("swhold");
            if (c == 5) readCheck("sdata.h5", 16'hFFF2, 16'h0000);
        end
        readCheck("sdata.h6", 16'hFFF2, 16'h0001);

        // Timer wrap at limit 3
        applyStimulus(curKey, curSw, 16'hFFFE, 16'd3, 1'b1, "tlim.wr");
        applyStimulus(curKey, curSw, 16'hFFF6, 16'd0, 1'b1, "tcnt.wr");
        for (int c = 1; c <= 40; c++) begin
            idle("timer");
            if (c == 9) readCheck("tcnt.c9", 16'hFFF6, 16'd0);
            if (c % 10 == 0) readCheck("tcnt.tick", 16'hFFF6, 16'((c / 10) % 4));
        end
        readCheck("kstat.wrap", 16'hFFF4, 16'h0010);

        // Output registers
        applyStimulus(curKey, curSw, 16'hFFF8, 16'hBEEF, 1'b1, "hex.wr");
        checkOutput("hexval.out", HEXVAL, 16'hBEEF);
        readCheck("hex.rd", 16'hFFF8, 16'hBEEF);
        applyStimulus(curKey, curSw, 16'hFFFA, 16'h03FF, 1'b1, "ledr.wr");
        checkOutput("ledr.out", {6'd0, LEDR}, 16'h03FF);
        readCheck("ledr.rd", 16'hFFFA, 16'h03FF);
        applyStimulus(curKey, curSw, 16'hFFFC, 16'h00A5, 1'b1, "ledg.wr");
        checkOutput("ledg.out", {8'd0, LEDG}, 16'h00A5);
        readCheck("ledg.rd", 16'hFFFC, 16'h00A5);

        // Clear of KSTAT[0] on the very edge it sets
        curKey = 4'b1110;
        for (int c = 1; c <= 5; c++) idle("collide.pre");
        ADDR = 16'hFFF4;
        #0.1;
        checkOutput("kstat0.before", {15'd0, DOUT[0]}, 16'd0);
        applyStimulus(curKey, curSw, 16'hFFF4, 16'h0001, 1'b1, "collide");
        ADDR = 16'hFFF4;
        #0.1;
        checkOutput("kstat0.setwins", {15'd0, DOUT[0]}, 16'd1);
        applyStimulus(curKey, curSw, 16'hFFF4, 16'h0001, 1'b1, "collide.clr");
        ADDR = 16'hFFF4;
        #0.1;
        checkOutput("kstat0.cleared", {15'd0, DOUT[0]}, 16'd0);

        // Reset in the middle of counting
        applyStimulus(curKey, curSw, 16'hFFF6, 16'd5, 1'b1, "tcnt5");
        idle("tcnt5.hold");
        readCheck("tcnt5.rd", 16'hFFF6, 16'd5);
        doReset("midrst");

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            logic [15:0] a;
            logic [15:0] d;
            logic        w;
            int          r;
            if ($urandom_range(0, 9) == 0) begin
                r = $urandom_range(0, 13);
                if (r < 4) curKey[r] = ~curKey[r];
                else curSw[r-4] = ~curSw[r-4];
            end
            r = $urandom_range(0, 9);
            a = (r < 8) ? mapAddr(r) : 16'($urandom_range(0, 32767));
            w = ($urandom_range(0, 3) == 0);
            d = 16'($urandom);
            if ((a == 16'hFFF6 || a == 16'hFFFE) && $urandom_range(0, 3) != 0)
                d = 16'($urandom_range(0, 8));
            applyStimulus(curKey, curSw, a, d, w, "random");
            if (n % 500 == 499) doReset("randrst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/io_responder.md
IO_RESPONDER -- requirements
Module: io_responder

Interface
REQ-001 SHALL have parameter DBITS, default 16: data bus width.
REQ-002 SHALL have parameter DEB_CYCLES, default 500000: consecutive stable cycles required to accept a key or switch change.
REQ-003 SHALL have parameter PRESCALE, default 50000: CLK cycles per timer tick, giving 1 ms at 50 MHz.
REQ-004 SHALL have port CLK, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-005 SHALL have port RESET_N, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port ADDR, input, DBITS bits: data-side bus address driven by the CPU.
REQ-007 SHALL have port DIN, input, DBITS bits: CPU write data.
REQ-008 SHALL have port WE, input, 1 bit: CPU write strobe; a write commits at the rising CLK edge.
REQ-009 SHALL have port DOUT, output, DBITS bits: read data.
REQ-010 SHALL have port SEL, output, 1 bit: high when ADDR is one of the mapped addresses.
REQ-011 SHALL have port KEY, input, 4 bits: raw pushbuttons, active-low, asynchronous.
REQ-012 SHALL have port SW, input, 10 bits: raw switches, asynchronous.
REQ-013 SHALL have port HEXVAL, output, 16 bits: value for the four seven-segment digits.
REQ-014 SHALL have port LEDR, output, 10 bits: red LEDs.
REQ-015 SHALL have port LEDG, output, 8 bits: green LEDs.

Function
REQ-016 SHALL use the following address map:
- 0xFFF0 KDATA: read-only, {12'b0, debounced pressed[3:0]}, where pressed = ~KEY.
- 0xFFF2 SDATA: read-only, {6'b0, debounced SW}.
- 0xFFF4 KSTAT: bits [3:0] sticky key-press flags, bit 4 timer wrap flag; write-1-to-clear.
- 0xFFF6 TCNT: read/write timer count.
- 0xFFF8 HEX, 0xFFFA LEDR, 0xFFFC LEDG: read/write output registers; read returns the value zero-extended.
- 0xFFFE TLIM: read/write timer limit.
REQ-017 SHALL make DOUT and SEL purely combinational from ADDR and register state: zero-latency reads. With SEL low, DOUT SHALL be 0x0000.
REQ-018 SHALL ignore writes to KDATA and SDATA, and writes to unmapped addresses.
REQ-019 SHALL pass each of the 14 raw inputs through a 2-flop synchronizer before debouncing.
REQ-020 SHALL give each input its own debounce counter:
- Synced value equal to the debounced value: counter clears to 0.
- Synced value differs: counter increments.
- On the edge where the counter would reach DEB_CYCLES: the debounced value takes the synced value and the counter clears.
REQ-021 SHALL set KSTAT[i] on the same edge that debounced pressed[i] goes 0->1; a 1->0 change SHALL NOT affect it.
REQ-022 SHALL resolve a simultaneous set event and write-1-to-clear of the same KSTAT bit with set winning. Writing 0 to a KSTAT bit SHALL leave it unchanged.
REQ-023 SHALL run the prescaler from 0 to PRESCALE-1 and then wrap; the wrap cycle is the tick.
REQ-024 SHALL update TCNT on each tick as follows:
- TLIM != 0 and TCNT == TLIM: TCNT becomes 0 and KSTAT[4] is set.
- Otherwise: TCNT increments modulo 2^16.
REQ-025 SHALL, on a CPU write to TCNT, load DIN into TCNT and clear the prescaler to 0; this write SHALL take priority over a tick in the same cycle.
REQ-026 SHALL apply a CPU write to TLIM from the next tick onward. If TLIM is written below the current TCNT, counting SHALL continue through 0xFFFF and wrap to 0 without setting KSTAT[4].
REQ-027 SHALL drive HEXVAL, LEDR and LEDG directly from their registers, taking DIN[15:0], DIN[9:0] and DIN[7:0] respectively.

Reset
REQ-028 SHALL, while RESET_N is low, immediately clear all of the following:
- HEX, LEDR, LEDG, TCNT, TLIM and KSTAT
- the prescaler and all debounce counters
- all synchronizer flops and all debounced values (the debounced key value 0 means not pressed)
REQ-029 SHALL produce no KSTAT set from reset release alone when KEY is held high.
REQ-030 SHALL, on reset mid-operation, abandon any in-progress debounce or tick with no residual effect.

Verification (DEB_CYCLES=4, PRESCALE=10)
REQ-031 Key press: hold KEY=4'b1101 from reset release. Required: KDATA reads 0x0002 and KSTAT reads 0x0002 from the 6th rising edge on. A write of 0x0002 to KSTAT then makes KSTAT read 0x0000.
REQ-032 Bounce rejection: toggle SW[0] every 3 cycles for 30 cycles. Required: SDATA stays 0x0000. Then hold SW[0]=1 and SDATA reads 0x0001 after 6 edges.
REQ-033 Timer wrap: write TLIM=3 and TCNT=0. Required: TCNT reads 1, 2, 3, 0 at 10, 20, 30, 40 cycles after the write, and KSTAT[4]=1 from cycle 40.
REQ-034 Output registers: write 0xBEEF to 0xFFF8, 0x03FF to 0xFFFA and 0x00A5 to 0xFFFC. Required: HEXVAL=0xBEEF, LEDR=0x3FF, LEDG=0xA5 on the edge after each write, and the same values read back at those addresses.
REQ-035 Set/clear collision: write 0x0001 to KSTAT on the exact edge that KSTAT[0] sets. Required: KSTAT[0] reads 1 afterwards.
REQ-036 Reset mid-count: with TCNT=5, pull RESET_N low for 1 cycle. Required: TCNT=0, HEXVAL=0, and DOUT at 0x1234 is 0x0000 with SEL=0.
